// File: rtl/alu_issue_ctrl.sv
// Issue sequencer between the decoder and the integer ALU/register file.
// Takes one instruction at a time: one EXEC cycle for ALU ops, or a 32-step signed divider for DIV/MOD.
module alu_issue_ctrl #(
    parameter int unsigned REG_AW = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [3:0]        i_req_op,
    input  logic [REG_AW-1:0] i_req_r0,
    input  logic [REG_AW-1:0] i_req_r1,
    input  logic [REG_AW-1:0] i_req_rd,
    output logic [REG_AW-1:0] o_rf_ra0,
    output logic [REG_AW-1:0] o_rf_ra1,
    input  logic [31:0]       i_rf_rd0,
    input  logic [31:0]       i_rf_rd1,
    output logic [31:0]       o_alu_d0,
    output logic [31:0]       o_alu_d1,
    output logic [3:0]        o_alu_op,
    input  logic [31:0]       i_alu_dout,
    output logic              o_wb_en,
    output logic [REG_AW-1:0] o_wb_addr,
    output logic [31:0]       o_wb_data,
    output logic              o_err_divz,
    output logic              o_busy
);

    typedef enum logic [1:0] {StIdle, StExec, StDiv, StWb} state_e;

    state_e            r_state;
    state_e            w_state_next;

    logic [3:0]        r_opr;
    logic [REG_AW-1:0] r_dst;
    logic [31:0]       r_opa;
    logic [31:0]       r_opb;
    logic              r_divz;
    logic [4:0]        r_cnt;
    logic [31:0]       r_rem;
    logic [31:0]       r_quo;
    logic [31:0]       r_dvs;
    logic [REG_AW-1:0] r_wb_addr;
    logic [31:0]       r_wb_data;

    logic              w_accept;
    logic              w_is_div;
    logic [31:0]       w_mag_a;
    logic [31:0]       w_mag_b;
    logic [31:0]       w_shift;
    logic [32:0]       w_trial;
    logic              w_fits;
    logic [31:0]       w_rem_next;
    logic [31:0]       w_quo_next;
    logic [31:0]       w_q_signed;
    logic [31:0]       w_r_signed;
    logic [31:0]       w_div_res;
    logic              w_last;

    assign w_accept = i_req_valid && (r_state == StIdle);
    assign w_is_div = (i_req_op == 4'hA) || (i_req_op == 4'hB);
    assign w_mag_a  = i_rf_rd0[31] ? -i_rf_rd0 : i_rf_rd0;
    assign w_mag_b  = i_rf_rd1[31] ? -i_rf_rd1 : i_rf_rd1;

    // Remainder stays below the divisor (<= 2^31), so the shifted value always fits in 32 bits.
    assign w_shift    = {r_rem[30:0], r_quo[31]};
    assign w_trial    = {1'b0, w_shift} - {1'b0, r_dvs};
    assign w_fits     = !w_trial[32];
    assign w_rem_next = w_fits ? w_trial[31:0] : w_shift;
    assign w_quo_next = {r_quo[30:0], w_fits};
    assign w_q_signed = (r_opa[31] ^ r_opb[31]) ? -w_quo_next : w_quo_next;
    assign w_r_signed = r_opa[31] ? -w_rem_next : w_rem_next;
    assign w_div_res  = (r_opr == 4'hB) ? w_r_signed : w_q_signed;
    assign w_last     = (r_state == StDiv) && (r_cnt == 5'd31);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_req_valid) w_state_next = w_is_div ? StDiv : StExec;
            StExec: w_state_next = StWb;
            StDiv:  if (r_cnt == 5'd31) w_state_next = StWb;
            StWb:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_req_ready = 1'b0;
        o_busy      = 1'b1;
        o_wb_en     = 1'b0;
        o_err_divz  = 1'b0;
        o_alu_op    = r_opr;
        o_alu_d0    = r_opa;
        o_alu_d1    = r_opb;
        unique case (r_state)
            StIdle: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
                o_alu_op    = 4'h0;
                o_alu_d0    = 32'h0;
                o_alu_d1    = 32'h0;
            end
            StWb: begin
                o_wb_en    = !r_divz;
                o_err_divz = r_divz;
            end
            default: ;
        endcase
    end

    assign o_rf_ra0  = i_req_r0;
    assign o_rf_ra1  = i_req_r1;
    assign o_wb_addr = r_wb_addr;
    assign o_wb_data = r_wb_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_opr     <= 4'h0;
            r_dst     <= '0;
            r_opa     <= 32'h0;
            r_opb     <= 32'h0;
            r_divz    <= 1'b0;
            r_cnt     <= 5'd0;
            r_rem     <= 32'h0;
            r_quo     <= 32'h0;
            r_dvs     <= 32'h0;
            r_wb_addr <= '0;
            r_wb_data <= 32'h0;
        end else begin
            if (w_accept) begin
                r_opr  <= i_req_op;
                r_dst  <= i_req_rd;
                r_opa  <= i_rf_rd0;
                r_opb  <= i_rf_rd1;
                r_divz <= w_is_div && (i_rf_rd1 == 32'h0);
                r_cnt  <= 5'd0;
                r_rem  <= 32'h0;
                r_quo  <= w_mag_a;
                r_dvs  <= w_mag_b;
            end
            if (r_state == StDiv) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt + 5'd1;
            end
            if (r_state == StExec) begin
                r_wb_addr <= r_dst;
                r_wb_data <= i_alu_dout;
            end
            // A divide-by-zero leaves the previous writeback values in place.
            if (w_last && !r_divz) begin
                r_wb_addr <= r_dst;
                r_wb_data <= w_div_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: register file and ALU environment plus an arithmetic reference model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [5:0]  req_r0 = '0, req_r1 = '0, req_rd = '0;
    logic [5:0]  rf_ra0, rf_ra1;
    logic [31:0] rf_rd0, rf_rd1;
    logic [31:0] alu_d0, alu_d1, alu_dout;
    logic [3:0]  alu_op;
    logic        wb_en, err_divz, busy;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;

    logic [31:0] rf  [64];
    logic [31:0] mdl [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.REG_AW(6)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
        .i_req_r0(req_r0), .i_req_r1(req_r1), .i_req_rd(req_rd),
        .o_rf_ra0(rf_ra0), .o_rf_ra1(rf_ra1), .i_rf_rd0(rf_rd0), .i_rf_rd1(rf_rd1),
        .o_alu_d0(alu_d0), .o_alu_d1(alu_d1), .o_alu_op(alu_op), .i_alu_dout(alu_dout),
        .o_wb_en(wb_en), .o_wb_addr(wb_addr), .o_wb_data(wb_data),
        .o_err_divz(err_divz), .o_busy(busy)
    );

    function automatic logic [31:0] env_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'h0: return a | b;
            4'h1: return a ^ b;
            4'h2: return a & b;
            4'h4: return a + b;
            4'h5: return a - b;
            4'h6: return a * b;
            4'h8: return a << b[4:0];
            4'h9: return $signed(a) >>> b[4:0];
            default: return (a ^ 32'h5A5A_5A5A) + {28'h0, op};
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb, q, r;
        if (op != 4'hA && op != 4'hB) return env_alu(op, a, b);
        if (b == 32'h0) return 32'h0;
        sa = a;
        sb = b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = sa;
            r = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return (op == 4'hA) ? q : r;
    endfunction

    assign rf_rd0   = rf[rf_ra0];
    assign rf_rd1   = rf[rf_ra1];
    assign alu_dout = env_alu(alu_op, alu_d0, alu_d1);

    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (wb_en) rf[wb_addr] <= wb_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input int addr, input logic [31:0] val);
        pre_we   = 1'b1;
        pre_addr = addr[5:0];
        pre_data = val;
        mdl[addr] = val;
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after writeback.
    task automatic run_instr(input logic [3:0] op, input int r0, input int r1, input int rd,
                             input bit keep);
        logic [31:0] a, b, exp;
        bit divz, is_div;
        int lat, cyc;
        bit seen;
        a = mdl[r0];
        b = mdl[r1];
        is_div = (op == 4'hA) || (op == 4'hB);
        divz = is_div && (b == 32'h0);
        exp = ref_result(op, a, b);
        lat = is_div ? 33 : 2;
        req_valid = 1'b1;
        req_op = op;
        req_r0 = r0[5:0];
        req_r1 = r1[5:0];
        req_rd = rd[5:0];
        check("ready_before_accept", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        if (!keep) req_valid = 1'b0;
        check("busy_c1", {31'h0, busy}, 32'h1);
        check("alu_op_c1", {28'h0, alu_op}, {28'h0, op});
        check("alu_d0_c1", alu_d0, a);
        check("alu_d1_c1", alu_d1, b);
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            if (wb_en || err_divz) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("wb_cycle", cyc, lat);
        if (divz) begin
            check("divz_wb_en", {31'h0, wb_en}, 32'h0);
            check("divz_err", {31'h0, err_divz}, 32'h1);
        end else begin
            check("wb_en", {31'h0, wb_en}, 32'h1);
            check("err_divz", {31'h0, err_divz}, 32'h0);
            check("wb_addr", {26'h0, wb_addr}, rd);
            check("wb_data", wb_data, exp);
            mdl[rd] = exp;
        end
        @(negedge clk);
        check("ready_after", {31'h0, req_ready}, 32'h1);
        check("pulse_len", {30'h0, wb_en, err_divz}, 32'h0);
        check("rf_content", rf[rd], mdl[rd]);
    endtask

    initial begin
        int pulses;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_wb", {30'h0, wb_en, err_divz}, 32'h0);
        check("rst_wb_addr", {26'h0, wb_addr}, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_alu_op", {28'h0, alu_op}, 32'h0);
        check("rst_alu_d", alu_d0 | alu_d1, 32'h0);
        for (int i = 0; i < 64; i++) set_reg(i, $urandom);
        set_reg(0, 32'h0);
        set_reg(1, 32'h8000_0000);
        set_reg(2, 32'hFFFF_FFFF);
        set_reg(3, 32'h7);
        reset = 1'b0;
        @(negedge clk);

        set_reg(10, 32'd3);
        set_reg(11, 32'd7);
        run_instr(4'h4, 10, 11, 12, 1'b0);
        check("add_3_7", rf[12], 32'd10);
        run_instr(4'h5, 10, 11, 12, 1'b0);
        check("sub_3_7", rf[12], 32'hFFFF_FFFC);
        set_reg(13, 32'h8000_0000);
        set_reg(14, 32'd4);
        run_instr(4'h9, 13, 14, 12, 1'b0);
        check("sar", rf[12], 32'hF800_0000);
        set_reg(15, -32'sd7);
        set_reg(16, 32'd2);
        set_reg(17, 32'd7);
        set_reg(18, -32'sd2);
        set_reg(19, 32'hFFFF_FFFF);
        set_reg(21, 32'd5);
        set_reg(22, 32'd0);
        set_reg(24, 32'h1234_5678);
        run_instr(4'hA, 15, 16, 23, 1'b0);
        check("div_m7_2", rf[23], 32'hFFFF_FFFD);
        run_instr(4'hB, 15, 16, 23, 1'b0);
        check("mod_m7_2", rf[23], 32'hFFFF_FFFF);
        run_instr(4'hB, 17, 18, 23, 1'b0);
        check("mod_7_m2", rf[23], 32'd1);
        run_instr(4'hA, 13, 19, 23, 1'b0);
        check("div_min_m1", rf[23], 32'h8000_0000);
        run_instr(4'hA, 21, 22, 24, 1'b0);
        check("divz_reg_kept", rf[24], 32'h1234_5678);

        set_reg(20, 32'd5);
        run_instr(4'h4, 20, 20, 20, 1'b1);
        run_instr(4'h4, 20, 20, 20, 1'b0);
        check("b2b_result", rf[20], 32'd20);

        // Reset while the divider is at cnt=10 (cycle 11).
        set_reg(25, 32'h0000_0100);
        req_valid = 1'b1;
        req_op = 4'hA;
        req_r0 = 6'd21;
        req_r1 = 6'd16;
        req_rd = 6'd25;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("arst_ready", {31'h0, req_ready}, 32'h1);
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_wb", {30'h0, wb_en, err_divz}, 32'h0);
        check("arst_wb_addr", {26'h0, wb_addr}, 32'h0);
        check("arst_wb_data", wb_data, 32'h0);
        check("arst_alu", {28'h0, alu_op} | alu_d0 | alu_d1, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wb_en || err_divz) pulses++;
        end
        check("arst_no_wb", pulses, 32'h0);
        check("arst_ready_after", {31'h0, req_ready}, 32'h1);
        check("arst_reg_kept", rf[25], 32'h0000_0100);

        for (int n = 0; n < 40; n++) begin
            run_instr(4'($urandom_range(0, 15)), $urandom_range(0, 63), $urandom_range(0, 63),
                      $urandom_range(4, 63), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
